// File: rtl/cdc_pkg.sv
// Shared types for the req/ack clock-domain crossing blocks.
// Holds the handshake FSM encoding and the default synchronizer depth.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ_HI,
    REQ_LO
  } hs_state_e;

  localparam int DEFAULT_SYNC_STAGES = 3;

endpackage

// File: rtl/chain_synchronizer.sv
// Multi-flop synchronizer: q_o is d_i delayed by exactly LENGTH edges.
// Ports: clk_i, reset_i (async active-low, clears to 0), d_i, q_o.
module chain_synchronizer #(
  parameter int LENGTH = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [LENGTH-1:0] ff_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) ff_q <= '0;
    else          ff_q <= {ff_q[LENGTH-2:0], d_i};
  end

  assign q_o = ff_q[LENGTH-1];

endmodule

// File: rtl/cdc_hs_tx_arbiter.sv
// Source side of a 4-phase req/ack crossing shared by N_REQ requesters.
// Ports: src_valid/data/ready (requesters), xfer_req/ack/data/tag, busy, done.
module cdc_hs_tx_arbiter
  import cdc_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int DATA_W      = 32,
  parameter  int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  localparam int TAG_W       = $clog2(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [N_REQ-1:0]        src_valid_i,
  input  logic [N_REQ*DATA_W-1:0] src_data_i,
  output logic [N_REQ-1:0]        src_ready_o,
  output logic                    xfer_req_o,
  input  logic                    xfer_ack_i,
  output logic [DATA_W-1:0]       xfer_data_o,
  output logic [TAG_W-1:0]        xfer_tag_o,
  output logic                    busy_o,
  output logic                    done_o
);

  hs_state_e         state_q, state_d;
  logic [TAG_W-1:0]  ptr_q, ptr_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              done_q, done_d;
  logic              ack_s;
  logic [TAG_W-1:0]  win;

  // First set bit at or above p, wrapping; descending scan keeps the
  // closest hit. Index stays in 0..N_REQ-1 for any N_REQ.
  function automatic logic [TAG_W-1:0] rr_pick(
    input logic [N_REQ-1:0] v,
    input logic [TAG_W-1:0] p
  );
    logic [TAG_W-1:0] r;
    int i;
    r = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      i = int'(p) + k;
      if (i >= N_REQ) i = i - N_REQ;
      if (v[i]) r = TAG_W'(i);
    end
    return r;
  endfunction

  chain_synchronizer #(
    .LENGTH (SYNC_STAGES)
  ) u_ack_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (xfer_ack_i),
    .q_o     (ack_s)
  );

  assign win = rr_pick(src_valid_i, ptr_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    req_d       = req_q;
    data_d      = data_q;
    tag_d       = tag_q;
    done_d      = 1'b0;
    src_ready_o = '0;
    unique case (state_q)
      IDLE: begin
        // A stale high ack must drain before a new request may start.
        if (!ack_s && |src_valid_i) begin
          src_ready_o[win] = 1'b1;
          data_d  = src_data_i[int'(win)*DATA_W +: DATA_W];
          tag_d   = win;
          req_d   = 1'b1;
          ptr_d   = (win == TAG_W'(N_REQ - 1)) ? '0 : win + TAG_W'(1);
          state_d = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      done_q  <= done_d;
    end
  end

  assign xfer_req_o  = req_q;
  assign xfer_data_o = data_q;
  assign xfer_tag_o  = tag_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_hs_tx_arbiter.sv
// Self-checking bench for cdc_hs_tx_arbiter with a transaction-level
// round-robin model and a destination ack model driven per transfer.
module tb_cdc_hs_tx_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           reset_i = 1'b0;
  logic [N-1:0]   src_valid_i = '0;
  logic [N*W-1:0] src_data_i = '0;
  logic [N-1:0]   src_ready_o;
  logic           xfer_req_o;
  logic           xfer_ack_i = 1'b0;
  logic [W-1:0]   xfer_data_o;
  logic [1:0]     xfer_tag_o;
  logic           busy_o;
  logic           done_o;

  int n_cmp = 0;
  int n_bad = 0;
  int m_ptr = 0;
  logic [W-1:0] exp_data;
  logic [1:0]   exp_tag;

  cdc_hs_tx_arbiter #(
    .N_REQ       (N),
    .DATA_W      (W),
    .SYNC_STAGES (S)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .src_valid_i (src_valid_i),
    .src_data_i  (src_data_i),
    .src_ready_o (src_ready_o),
    .xfer_req_o  (xfer_req_o),
    .xfer_ack_i  (xfer_ack_i),
    .xfer_data_o (xfer_data_o),
    .xfer_tag_o  (xfer_tag_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [N*W-1:0] rand_bus();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  // Round-robin reference: first valid index scanning upward from the
  // model pointer, modulo N.
  function automatic int exp_winner(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int k = N - 1; k >= 0; k--)
      if (v[(m_ptr + k) % N]) r = (m_ptr + k) % N;
    return r;
  endfunction

  task automatic start_xfer(input logic [N-1:0] v,
                            input logic [N*W-1:0] d,
                            output int w);
    logic [N-1:0] er;
    src_valid_i = v;
    src_data_i  = d;
    #1;
    w  = exp_winner(v);
    er = N'(1) << w;
    n_cmp++;
    if (src_ready_o !== er) begin
      n_bad++;
      $display("FAIL ready: got %b want %b", src_ready_o, er);
    end
    tick();
    exp_data = d[w*W +: W];
    exp_tag  = 2'(w);
    m_ptr    = (w + 1) % N;
    n_cmp++;
    if (xfer_req_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL accept_ctl: got req=%b busy=%b done=%b want 1 1 0",
               xfer_req_o, busy_o, done_o);
    end
    n_cmp++;
    if (xfer_data_o !== exp_data || xfer_tag_o !== exp_tag) begin
      n_bad++;
      $display("FAIL capture: got %h/%0d want %h/%0d",
               xfer_data_o, xfer_tag_o, exp_data, exp_tag);
    end
  endtask

  task automatic scramble();
    src_valid_i = N'($urandom);
    src_data_i  = rand_bus();
  endtask

  task automatic finish_xfer(input int dly);
    bit ok;
    int cnt;
    ok = 1'b1;
    for (int i = 0; i < dly; i++) begin
      tick();
      if (xfer_req_o !== 1'b1 || xfer_data_o !== exp_data ||
          xfer_tag_o !== exp_tag) ok = 1'b0;
      scramble();
      #1;
      if (src_ready_o !== '0) ok = 1'b0;
    end
    xfer_ack_i = 1'b1;
    cnt = 0;
    do begin
      tick();
      cnt++;
      if (xfer_data_o !== exp_data || xfer_tag_o !== exp_tag ||
          busy_o !== 1'b1 || done_o !== 1'b0) ok = 1'b0;
      scramble();
      #1;
      if (src_ready_o !== '0) ok = 1'b0;
    end while (xfer_req_o === 1'b1 && cnt < 40);
    n_cmp++;
    if (cnt !== S + 1) begin
      n_bad++;
      $display("FAIL req_fall: got %0d edges want %0d", cnt, S + 1);
    end
    for (int i = 0; i < dly; i++) begin
      tick();
      if (xfer_req_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b1 ||
          xfer_data_o !== exp_data) ok = 1'b0;
      scramble();
    end
    xfer_ack_i = 1'b0;
    cnt = 0;
    do begin
      tick();
      cnt++;
      if (xfer_data_o !== exp_data || xfer_tag_o !== exp_tag ||
          xfer_req_o !== 1'b0) ok = 1'b0;
      if (done_o !== 1'b1) scramble();
    end while (done_o !== 1'b1 && cnt < 40);
    n_cmp++;
    if (cnt !== S + 1) begin
      n_bad++;
      $display("FAIL done_delay: got %0d edges want %0d", cnt, S + 1);
    end
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_at_done: got busy=%b want 0", busy_o);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL hold: got unstable bus/ready during transfer want stable");
    end
    src_valid_i = '0;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (xfer_req_o !== 1'b0 || xfer_data_o !== '0 || xfer_tag_o !== '0 ||
        done_o !== 1'b0 || busy_o !== 1'b0 || src_ready_o !== '0) begin
      n_bad++;
      $display("FAIL reset: got req=%b data=%h tag=%0d done=%b busy=%b want 0s",
               xfer_req_o, xfer_data_o, xfer_tag_o, done_o, busy_o);
    end
    reset_i = 1'b1;
    m_ptr = 0;
    tick();
  endtask

  task automatic test_single();
    logic [N*W-1:0] d;
    int w;
    d = rand_bus();
    d[2*W +: W] = 32'hDEADBEEF;
    start_xfer(4'b0100, d, w);
    n_cmp++;
    if (xfer_data_o !== 32'hDEADBEEF || xfer_tag_o !== 2'd2) begin
      n_bad++;
      $display("FAIL single: got %h/%0d want deadbeef/2", xfer_data_o, xfer_tag_o);
    end
    finish_xfer(2);
  endtask

  task automatic test_round_robin();
    int w;
    start_xfer(4'b1000, rand_bus(), w);
    finish_xfer(1);
    for (int i = 0; i < 8; i++) begin
      start_xfer(4'b1111, rand_bus(), w);
      n_cmp++;
      if (w !== i % N) begin
        n_bad++;
        $display("FAIL rr_order: got %0d want %0d", w, i % N);
      end
      finish_xfer(i % 3);
    end
  endtask

  task automatic test_wrap();
    int w;
    start_xfer(4'b0001, rand_bus(), w);
    finish_xfer(0);
    start_xfer(4'b1001, rand_bus(), w);
    n_cmp++;
    if (w !== 3) begin
      n_bad++;
      $display("FAIL wrap_first: got %0d want 3", w);
    end
    finish_xfer(1);
    start_xfer(4'b1001, rand_bus(), w);
    n_cmp++;
    if (w !== 0) begin
      n_bad++;
      $display("FAIL wrap_second: got %0d want 0", w);
    end
    finish_xfer(1);
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 16; i++) begin
      start_xfer(N'($urandom_range(1, 15)), rand_bus(), w);
      finish_xfer($urandom_range(0, 3));
    end
  endtask

  task automatic test_stale_ack();
    bit ok;
    int cnt;
    xfer_ack_i = 1'b1;
    #1;
    reset_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b1;
    m_ptr = 0;
    repeat (S + 2) tick();
    src_valid_i = 4'b0001;
    src_data_i  = rand_bus();
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (src_ready_o !== '0 || xfer_req_o !== 1'b0) ok = 1'b0;
      tick();
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL stale_ack: got grant while ack high want none");
    end
    xfer_ack_i = 1'b0;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (xfer_req_o !== 1'b1 && cnt < 40);
    n_cmp++;
    if (cnt !== S + 1) begin
      n_bad++;
      $display("FAIL stale_grant: got %0d edges want %0d", cnt, S + 1);
    end
    exp_data = src_data_i[0 +: W];
    exp_tag  = 2'd0;
    m_ptr    = 1;
    n_cmp++;
    if (xfer_data_o !== exp_data || xfer_tag_o !== 2'd0) begin
      n_bad++;
      $display("FAIL stale_capture: got %h/%0d want %h/0",
               xfer_data_o, xfer_tag_o, exp_data);
    end
    finish_xfer(1);
  endtask

  task automatic test_reset_mid();
    int w;
    start_xfer(4'b0100, rand_bus(), w);
    #1;
    reset_i = 1'b0;
    #1;
    n_cmp++;
    if (xfer_req_o !== 1'b0 || busy_o !== 1'b0 || xfer_data_o !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got req=%b busy=%b data=%h want 0 0 0",
               xfer_req_o, busy_o, xfer_data_o);
    end
    src_valid_i = '0;
    tick();
    reset_i = 1'b1;
    m_ptr = 0;
    tick();
    start_xfer(4'b0010, rand_bus(), w);
    n_cmp++;
    if (w !== 1 || xfer_tag_o !== 2'd1) begin
      n_bad++;
      $display("FAIL reset_recover: got tag %0d want 1", xfer_tag_o);
    end
    finish_xfer(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_random();
    test_stale_ack();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
